id_ex_register: RTL and testbench
=================================

# id_ex_register

Pipeline register between Instruction Decode and Execute in the 5-stage RISC-V core. It captures decoded operands, immediates, register indices, the 4-bit ALU function field and the control bundle each cycle. It presents them to the EX stage: the ALU control decoder consumes `ex_aluop`/`ex_funct`, and the ALU and forwarding unit consume the rest. It supports hold (stall), bubble insertion (flush) and a saturating bubble counter for performance inspection.

## Interface
- `XLEN`, default 64: datapath width.
- `CNT_W`, default 32: bubble counter width.

- `clk`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: hold all stored contents (hazard unit, load-use on younger stage).
- `flush`  in  1: replace the next captured entry with a bubble (branch taken / load-use bubble).
- `id_valid`  in  1: ID holds a real instruction.
- `id_pc`  in  XLEN: instruction PC.
- `id_rs1_data`, `id_rs2_data`  in  XLEN each: register file read data.
- `id_imm`  in  XLEN: sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each: register indices.
- `id_funct`  in  4: {instr[30], instr[14:12]}.
- `id_aluop`  in  2: 00 load/store add, 01 branch subtract, 10 R-type decode.
- `id_alusrc`, `id_branch`, `id_memread`, `id_memwrite`, `id_memtoreg`, `id_regwrite`  in  1 each.
- `ex_*`  out: registered copies of every `id_*` input above, same widths, plus `ex_valid`.
- `bubble_count`  out  CNT_W: number of bubbles inserted since reset.

## Operation
- Per-edge priority: `reset` > `flush` > `stall` > load.
- Load: every `ex_*` <= matching `id_*`; `ex_valid` <= `id_valid`.
- Flush: `ex_valid`, all six 1-bit controls, `ex_aluop` <= 0. Data, index and funct fields <= 0, giving a deterministic bubble: `ex_aluop`=00 decodes to add, and `ex_rd`=0, `ex_regwrite`=0 guarantee no architectural effect.
- Stall without flush: all `ex_*` retain their values; `bubble_count` unchanged.
- Flush with stall: flush wins and the bubble is inserted.
- `bubble_count` increments by 1 on every edge where flush is applied and `reset`=0. It saturates at all-ones and does not wrap.
- `id_valid`=0 on a load edge is captured as-is. Controls are not masked; ID is responsible for zeroing them. This does not count as a bubble.

## Timing
- Latency: 1 cycle. Values present on `id_*` at edge N appear on `ex_*` after edge N.
- Reset: all `ex_*` outputs 0 and `bubble_count`=0 after the first edge with `reset`=1. Outputs stay 0 while `reset` is held.
- Reset mid-stall or mid-flush: reset wins; no count increment on that edge.
- Release of `stall`: the next edge loads the current `id_*`. No extra bubble is implied.
- No combinational path from any input to any output.

## Structure
- Shared package `core_pkg` holds:
  - `aluop_t` with constants ALUOP_MEM=2'b00, ALUOP_BR=2'b01, ALUOP_RTYPE=2'b10;
  - funct constants F_ADD=4'b0000, F_SUB=4'b1000, F_AND=4'b0111, F_OR=4'b0110;
  - `ex_ctrl_t` packed struct {aluop, alusrc, branch, memread, memwrite, memtoreg, regwrite}. The IF/ID and EX/MEM registers reuse this struct.
- One sub-module: `pipe_reg`. It is a generic width-parameterised register with `reset`, `clear` (sync zero) and `en`, instantiated once per field group (data, indices, control). The counter and priority logic live in the top module.

## Test plan
- Reset: hold `reset` 2 cycles with random `id_*` -> all `ex_*`=0, `bubble_count`=0. Release -> next edge loads `id_*`.
- Normal flow: `id_pc`=0x100, `id_aluop`=10, `id_funct`=1000, `id_rd`=5, `id_regwrite`=1 -> one edge later `ex_*` match exactly. Alternate with ALUOP_MEM/ALUOP_BR entries every cycle -> no drop or duplication.
- Stall: load PC 0x200, then assert `stall` 3 cycles while `id_*` changes to PC 0x204 -> `ex_pc` stays 0x200 for 3 cycles, then becomes 0x204.
- Flush: `id_regwrite`=1, `id_rd`=7, `flush`=1 -> `ex_valid`=0, `ex_regwrite`=0, `ex_rd`=0, `ex_aluop`=00, `bubble_count` +1.
- Flush+stall same edge -> bubble inserted, `bubble_count` +1. Reset+flush same edge -> outputs 0, count 0.
- Saturation: with `CNT_W`=4, apply 20 flushes -> `bubble_count` reaches 15 and holds at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: ALU operation classes, funct encodings and the EX-stage
// control bundle reused by the IF/ID, ID/EX and EX/MEM pipeline registers.
package core_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_t;

  // funct = {instr[30], instr[14:12]}
  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b1000;
  localparam logic [3:0] F_AND = 4'b0111;
  localparam logic [3:0] F_OR  = 4'b0110;

  localparam int REG_IDX_W = 5;
  localparam int FUNCT_W   = 4;

  typedef struct packed {
    aluop_t aluop;
    logic   alusrc;
    logic   branch;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   regwrite;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_register_if.sv
// ID->EX pipeline bus: decode-side inputs and their registered EX-side copies.
interface id_ex_register_if #(
  parameter int XLEN = 64
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [3:0]      id_funct;
  logic [1:0]      id_aluop;
  logic            id_alusrc;
  logic            id_branch;
  logic            id_memread;
  logic            id_memwrite;
  logic            id_memtoreg;
  logic            id_regwrite;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [3:0]      ex_funct;
  logic [1:0]      ex_aluop;
  logic            ex_alusrc;
  logic            ex_branch;
  logic            ex_memread;
  logic            ex_memwrite;
  logic            ex_memtoreg;
  logic            ex_regwrite;

  // Decode stage drives id_*, and sees the EX-side copies.
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct, id_aluop,
           id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct, ex_aluop,
           ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite
  );

  // The pipeline register samples id_* and drives ex_*.
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct, id_aluop,
           id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct, ex_aluop,
           ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite
  );
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset, synchronous clear and
// load enable. reset and clear both zero the contents; clear beats en.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decoded operands and controls, supports
// stall (hold) and flush (zero bubble), and counts inserted bubbles.
module id_ex_register
  import core_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  id_ex_register_if.slave    bus,
  output logic [CNT_W-1:0]   bubble_count
);

  localparam int DATA_W = 4 * XLEN;
  localparam int IDX_W  = 3 * REG_IDX_W + FUNCT_W;
  localparam int CTRL_W = 1 + $bits(ex_ctrl_t);

  logic [DATA_W-1:0] data_d, data_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [CTRL_W-1:0] ctrl_grp_d, ctrl_grp_q;
  ex_ctrl_t          ctrl_d, ctrl_q;
  logic              valid_q;
  logic              load_en;

  // Flush is wired to clear, which pipe_reg ranks above en, so flush wins
  // over stall without any extra gating here.
  assign load_en = ~stall;

  assign data_d = {bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm};
  assign idx_d  = {bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_funct};

  assign ctrl_d = '{
    aluop:    aluop_t'(bus.id_aluop),
    alusrc:   bus.id_alusrc,
    branch:   bus.id_branch,
    memread:  bus.id_memread,
    memwrite: bus.id_memwrite,
    memtoreg: bus.id_memtoreg,
    regwrite: bus.id_regwrite
  };
  assign ctrl_grp_d = {bus.id_valid, ctrl_d};

  pipe_reg #(.W(DATA_W)) u_data_reg (
    .clk(clk), .reset(reset), .clear(flush), .en(load_en),
    .d(data_d), .q(data_q)
  );

  pipe_reg #(.W(IDX_W)) u_idx_reg (
    .clk(clk), .reset(reset), .clear(flush), .en(load_en),
    .d(idx_d), .q(idx_q)
  );

  pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk(clk), .reset(reset), .clear(flush), .en(load_en),
    .d(ctrl_grp_d), .q(ctrl_grp_q)
  );

  assign {valid_q, ctrl_q} = ctrl_grp_q;

  assign {bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm} = data_q;
  assign {bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct}         = idx_q;

  assign bus.ex_valid    = valid_q;
  assign bus.ex_aluop    = ctrl_q.aluop;
  assign bus.ex_alusrc   = ctrl_q.alusrc;
  assign bus.ex_branch   = ctrl_q.branch;
  assign bus.ex_memread  = ctrl_q.memread;
  assign bus.ex_memwrite = ctrl_q.memwrite;
  assign bus.ex_memtoreg = ctrl_q.memtoreg;
  assign bus.ex_regwrite = ctrl_q.regwrite;

  // Saturating bubble counter.
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // NOTE: cnt_d is given its default first so no path through this block leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized self-checking bench for id_ex_register with a transaction-level
// reference model; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_register;

  localparam int XLEN = 64;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      funct;
    logic [1:0]      aluop;
    logic            alusrc;
    logic            branch;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            regwrite;
  } entry_t;

  logic clk = 1'b0;
  logic reset, stall, flush;
  entry_t in_e, exp_e, obs_main, obs_sat;
  longint exp_cnt;
  logic [31:0] bubble_count;
  logic [3:0]  bubble_count_sat;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_register_if #(.XLEN(XLEN)) bus ();
  id_ex_register_if #(.XLEN(XLEN)) bus_sat ();

  assign bus.id_valid    = in_e.valid;
  assign bus.id_pc       = in_e.pc;
  assign bus.id_rs1_data = in_e.rs1_data;
  assign bus.id_rs2_data = in_e.rs2_data;
  assign bus.id_imm      = in_e.imm;
  assign bus.id_rs1      = in_e.rs1;
  assign bus.id_rs2      = in_e.rs2;
  assign bus.id_rd       = in_e.rd;
  assign bus.id_funct    = in_e.funct;
  assign bus.id_aluop    = in_e.aluop;
  assign bus.id_alusrc   = in_e.alusrc;
  assign bus.id_branch   = in_e.branch;
  assign bus.id_memread  = in_e.memread;
  assign bus.id_memwrite = in_e.memwrite;
  assign bus.id_memtoreg = in_e.memtoreg;
  assign bus.id_regwrite = in_e.regwrite;

  assign bus_sat.id_valid    = in_e.valid;
  assign bus_sat.id_pc       = in_e.pc;
  assign bus_sat.id_rs1_data = in_e.rs1_data;
  assign bus_sat.id_rs2_data = in_e.rs2_data;
  assign bus_sat.id_imm      = in_e.imm;
  assign bus_sat.id_rs1      = in_e.rs1;
  assign bus_sat.id_rs2      = in_e.rs2;
  assign bus_sat.id_rd       = in_e.rd;
  assign bus_sat.id_funct    = in_e.funct;
  assign bus_sat.id_aluop    = in_e.aluop;
  assign bus_sat.id_alusrc   = in_e.alusrc;
  assign bus_sat.id_branch   = in_e.branch;
  assign bus_sat.id_memread  = in_e.memread;
  assign bus_sat.id_memwrite = in_e.memwrite;
  assign bus_sat.id_memtoreg = in_e.memtoreg;
  assign bus_sat.id_regwrite = in_e.regwrite;

  assign obs_main = {bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
                     bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct, bus.ex_aluop,
                     bus.ex_alusrc, bus.ex_branch, bus.ex_memread, bus.ex_memwrite,
                     bus.ex_memtoreg, bus.ex_regwrite};
  assign obs_sat  = {bus_sat.ex_valid, bus_sat.ex_pc, bus_sat.ex_rs1_data, bus_sat.ex_rs2_data,
                     bus_sat.ex_imm, bus_sat.ex_rs1, bus_sat.ex_rs2, bus_sat.ex_rd,
                     bus_sat.ex_funct, bus_sat.ex_aluop, bus_sat.ex_alusrc, bus_sat.ex_branch,
                     bus_sat.ex_memread, bus_sat.ex_memwrite, bus_sat.ex_memtoreg,
                     bus_sat.ex_regwrite};

  id_ex_register #(.XLEN(XLEN), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .bus(bus.slave), .bubble_count(bubble_count)
  );

  id_ex_register #(.XLEN(XLEN), .CNT_W(4)) u_dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .bus(bus_sat.slave), .bubble_count(bubble_count_sat)
  );

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t rand_entry();
    entry_t e;
    e.valid    = 1'($urandom);
    e.pc       = {$urandom, $urandom};
    e.rs1_data = {$urandom, $urandom};
    e.rs2_data = {$urandom, $urandom};
    e.imm      = {$urandom, $urandom};
    e.rs1      = 5'($urandom);
    e.rs2      = 5'($urandom);
    e.rd       = 5'($urandom);
    e.funct    = 4'($urandom);
    e.aluop    = 2'($urandom_range(0, 2));
    e.alusrc   = 1'($urandom);
    e.branch   = 1'($urandom);
    e.memread  = 1'($urandom);
    e.memwrite = 1'($urandom);
    e.memtoreg = 1'($urandom);
    e.regwrite = 1'($urandom);
    return e;
  endfunction

  // One clock edge: advance the reference model by the edge rules, then
  // compare both instances once outputs have settled.
  task automatic step();
    longint sat_exp;
    @(posedge clk);
    if (reset) begin
      exp_e   = '0;
      exp_cnt = 0;
    end else if (flush) begin
      exp_e   = '0;
      exp_cnt = exp_cnt + 1;
    end else if (!stall) begin
      exp_e = in_e;
    end
    #1;
    sat_exp = (exp_cnt > 15) ? 15 : exp_cnt;
    check("entry", obs_main, exp_e);
    check("sat_entry", obs_sat, exp_e);
    check("count", bubble_count, 300'(exp_cnt));
    check("sat_count", bubble_count_sat, 300'(sat_exp));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t e;
    longint cnt_before;
    exp_e   = '0;
    exp_cnt = 0;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    in_e  = rand_entry();

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_zero", obs_main, '0);
      check("rst_cnt", bubble_count, '0);
      in_e = rand_entry();
    end
    reset = 1'b0;
    step();

    // Normal flow: R-type SUB.
    e = '0;
    e.valid = 1'b1; e.pc = 64'h100; e.aluop = 2'b10; e.funct = 4'b1000;
    e.rd = 5'd5; e.regwrite = 1'b1;
    in_e = e;
    step();
    check("nf_pc", bus.ex_pc, 64'h100);
    check("nf_aluop", bus.ex_aluop, 2'b10);
    check("nf_funct", bus.ex_funct, 4'b1000);
    check("nf_rd", bus.ex_rd, 5'd5);
    check("nf_regwrite", bus.ex_regwrite, 1'b1);

    // Back-to-back alternating MEM / BR entries.
    for (int i = 0; i < 8; i++) begin
      e = rand_entry();
      e.aluop = (i % 2 == 0) ? 2'b00 : 2'b01;
      e.pc = 64'h1000 + 64'(4 * i);
      in_e = e;
      step();
      check("alt_pc", bus.ex_pc, 64'h1000 + 64'(4 * i));
    end

    // Stall holds 0x200 for three cycles, release loads 0x204.
    e = rand_entry(); e.pc = 64'h200; in_e = e;
    step();
    stall = 1'b1;
    e = rand_entry(); e.pc = 64'h204; in_e = e;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.ex_pc, 64'h200);
    end
    stall = 1'b0;
    step();
    check("release_pc", bus.ex_pc, 64'h204);

    // Flush turns a writing instruction into a bubble.
    e = rand_entry(); e.valid = 1'b1; e.regwrite = 1'b1; e.rd = 5'd7; in_e = e;
    cnt_before = exp_cnt;
    flush = 1'b1;
    step();
    check("fl_valid", bus.ex_valid, 1'b0);
    check("fl_regwrite", bus.ex_regwrite, 1'b0);
    check("fl_rd", bus.ex_rd, 5'd0);
    check("fl_aluop", bus.ex_aluop, 2'b00);
    check("fl_cnt", bubble_count, 300'(cnt_before + 1));

    // Flush together with stall still inserts a bubble.
    stall = 1'b1;
    step();
    check("flst_cnt", bubble_count, 300'(cnt_before + 2));
    stall = 1'b0;

    // Reset together with flush: reset wins, count cleared.
    reset = 1'b1;
    step();
    check("rstfl_cnt", bubble_count, '0);
    check("rstfl_zero", obs_main, '0);
    reset = 1'b0;

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      in_e = rand_entry();
      step();
    end
    check("sat_hold", bubble_count_sat, 4'd15);
    check("nosat_20", bubble_count, 32'd20);
    flush = 1'b0;

    // Random mix of loads, stalls, flushes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      in_e  = rand_entry();
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 6) == 0;
      reset = ($urandom % 50) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
